// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_ctrl
// Desc     : Fetch sequencer for a combinational-read instruction memory,
//            feeding decode through an in-order valid/ready queue.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
    parameter int          DEPTH     = 2,
    parameter int          MEM_WORDS = 32,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic [31:0]            imem_addr_o,
    input  logic [31:0]            imem_instr_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [31:0]            instr_o,
    output logic [31:0]            instr_pc_o,
    input  logic                   redirect_i,
    input  logic [31:0]            redirect_pc_i,
    input  logic                   halt_i,
    output logic                   oob_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int                   c_PTR_W   = $clog2(DEPTH);
    localparam int                   c_CNT_W   = c_PTR_W + 1;
    localparam logic [32:0]          c_MEM_END = 33'(MEM_WORDS) * 33'd4;
    localparam logic [c_CNT_W-1:0]   c_FULL    = c_CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_OOB   = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_fetch_pc;
    logic [31:0]          w_fetch_pc_nxt;
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;
    logic [31:0]          r_q_instr [DEPTH];
    logic [31:0]          r_q_pc    [DEPTH];

    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_pc_oob;
    logic                 w_unused;

    // Redirect targets are word aligned; the low address bits carry no meaning.
    assign w_unused = ^redirect_pc_i[1:0];

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_FULL);
    assign w_pop    = !w_empty && instr_ready_i;
    assign w_pc_oob = ({1'b0, r_fetch_pc} >= c_MEM_END);

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_push         = 1'b0;
        if (redirect_i) begin
            w_state_nxt    = ST_FETCH;
            w_fetch_pc_nxt = {redirect_pc_i[31:2], 2'b00};
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_pc_oob) begin
                        w_state_nxt = ST_OOB;
                    end else if (!halt_i && (!w_full || w_pop)) begin
                        w_push         = 1'b1;
                        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    end
                end
                ST_OOB: begin
                    w_state_nxt = ST_OOB;
                end
                default: begin
                    w_state_nxt = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_FETCH;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    // A redirect flushes everything, including a pop accepted in the same cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (redirect_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
            end
        end else if (w_push) begin
            r_q_instr[r_tail] <= imem_instr_i;
            r_q_pc[r_tail]    <= r_fetch_pc;
        end
    end

    assign imem_addr_o   = r_fetch_pc;
    assign instr_valid_o = !w_empty;
    assign instr_o       = w_empty ? 32'd0 : r_q_instr[r_head];
    assign instr_pc_o    = w_empty ? 32'd0 : r_q_pc[r_head];
    assign oob_o         = (r_state == ST_OOB);
    assign count_o       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_ctrl
// Desc     : Self-checking bench for instr_fetch_ctrl (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

    localparam int          DEPTH     = 2;
    localparam int          MEM_WORDS = 32;
    localparam logic [31:0] RESET_PC  = 32'd0;
    localparam int          CW        = $clog2(DEPTH) + 1;
    localparam int          AW        = $clog2(MEM_WORDS);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [31:0]   imem_addr_o;
    logic [31:0]   imem_instr_i;
    logic          instr_valid_o;
    logic          instr_ready_i = 1'b0;
    logic [31:0]   instr_o;
    logic [31:0]   instr_pc_o;
    logic          redirect_i = 1'b0;
    logic [31:0]   redirect_pc_i = 32'd0;
    logic          halt_i = 1'b0;
    logic          oob_o;
    logic [CW-1:0] count_o;

    logic [31:0]   mem [MEM_WORDS];
    int            n_cmp = 0;
    int            n_err = 0;

    instr_fetch_ctrl #(
        .DEPTH     (DEPTH),
        .MEM_WORDS (MEM_WORDS),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .oob_o         (oob_o),
        .count_o       (count_o)
    );

    always #5 clk_i = ~clk_i;

    assign imem_instr_i = (imem_addr_o < 32'(MEM_WORDS * 4)) ? mem[imem_addr_o[AW+1:2]]
                                                             : (32'hBAD0_0000 ^ imem_addr_o);

    task automatic test_reset();
        #2 rst_i = 1'b0;
        instr_ready_i = 1'b1;
        halt_i = 1'b0;
        redirect_i = 1'b0;
        @(negedge clk_i);
        n_cmp++; if (count_o !== '0)          begin n_err++; $display("FAIL reset_count: got %0d want 0", count_o); end
        n_cmp++; if (instr_valid_o !== 1'b0)  begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
        n_cmp++; if (instr_o !== 32'd0)       begin n_err++; $display("FAIL reset_instr: got %h want 0", instr_o); end
        n_cmp++; if (instr_pc_o !== 32'd0)    begin n_err++; $display("FAIL reset_pc: got %h want 0", instr_pc_o); end
        n_cmp++; if (oob_o !== 1'b0)          begin n_err++; $display("FAIL reset_oob: got %b want 0", oob_o); end
        n_cmp++; if (imem_addr_o !== RESET_PC) begin n_err++; $display("FAIL reset_addr: got %h want %h", imem_addr_o, RESET_PC); end
        rst_i = 1'b1;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", k, instr_valid_o); end
            n_cmp++; if (instr_pc_o !== 32'(4 * k)) begin n_err++; $display("FAIL stream_pc[%0d]: got %h want %h", k, instr_pc_o, 32'(4 * k)); end
            n_cmp++; if (instr_o !== 32'h1000_0000 + 32'(k)) begin n_err++; $display("FAIL stream_instr[%0d]: got %h want %h", k, instr_o, 32'h1000_0000 + 32'(k)); end
            n_cmp++; if (count_o !== CW'(1)) begin n_err++; $display("FAIL stream_count[%0d]: got %0d want 1", k, count_o); end
        end
    endtask

    task automatic test_backpressure();
        redirect_i = 1'b1;
        redirect_pc_i = 32'd0;
        instr_ready_i = 1'b0;
        @(negedge clk_i);
        redirect_i = 1'b0;
        n_cmp++; if (count_o !== '0) begin n_err++; $display("FAIL bp_flush_count: got %0d want 0", count_o); end
        n_cmp++; if (imem_addr_o !== 32'd0) begin n_err++; $display("FAIL bp_flush_addr: got %h want 0", imem_addr_o); end
        repeat (5) @(negedge clk_i);
        n_cmp++; if (count_o !== CW'(2)) begin n_err++; $display("FAIL bp_count: got %0d want 2", count_o); end
        n_cmp++; if (imem_addr_o !== 32'd8) begin n_err++; $display("FAIL bp_addr: got %h want 8", imem_addr_o); end
        n_cmp++; if (instr_pc_o !== 32'd0) begin n_err++; $display("FAIL bp_head_pc: got %h want 0", instr_pc_o); end
        n_cmp++; if (instr_o !== 32'h1000_0000) begin n_err++; $display("FAIL bp_head_instr: got %h want 10000000", instr_o); end
        instr_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (instr_pc_o !== 32'(4 * k)) begin n_err++; $display("FAIL bp_drain_pc[%0d]: got %h want %h", k, instr_pc_o, 32'(4 * k)); end
            n_cmp++; if (instr_o !== 32'h1000_0000 + 32'(k)) begin n_err++; $display("FAIL bp_drain_instr[%0d]: got %h want %h", k, instr_o, 32'h1000_0000 + 32'(k)); end
            @(negedge clk_i);
        end
    endtask

    task automatic test_redirect_full();
        instr_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        n_cmp++; if (count_o !== CW'(2)) begin n_err++; $display("FAIL rd_full_count: got %0d want 2", count_o); end
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0043;
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        redirect_i = 1'b0;
        n_cmp++; if (count_o !== '0) begin n_err++; $display("FAIL rd_count: got %0d want 0", count_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_valid: got %b want 0", instr_valid_o); end
        n_cmp++; if (imem_addr_o !== 32'h40) begin n_err++; $display("FAIL rd_addr: got %h want 40", imem_addr_o); end
        @(negedge clk_i);
        n_cmp++; if (instr_pc_o !== 32'h40) begin n_err++; $display("FAIL rd_first_pc: got %h want 40", instr_pc_o); end
        n_cmp++; if (instr_o !== 32'h1000_0010) begin n_err++; $display("FAIL rd_first_instr: got %h want 10000010", instr_o); end
        @(negedge clk_i);
        n_cmp++; if (instr_pc_o !== 32'h44) begin n_err++; $display("FAIL rd_second_pc: got %h want 44", instr_pc_o); end
    endtask

    task automatic test_end_of_memory();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h78;
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        redirect_i = 1'b0;
        @(negedge clk_i);
        n_cmp++; if (instr_pc_o !== 32'h78) begin n_err++; $display("FAIL eom_pc78: got %h want 78", instr_pc_o); end
        @(negedge clk_i);
        n_cmp++; if (instr_pc_o !== 32'h7C) begin n_err++; $display("FAIL eom_pc7c: got %h want 7c", instr_pc_o); end
        n_cmp++; if (instr_o !== 32'h1000_001F) begin n_err++; $display("FAIL eom_instr7c: got %h want 1000001f", instr_o); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (oob_o === 1'b1) break;
            n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL eom_extra: got valid pc %h want none", instr_pc_o); end
        end
        n_cmp++; if (oob_o !== 1'b1) begin n_err++; $display("FAIL eom_oob: got %b want 1", oob_o); end
        n_cmp++; if (imem_addr_o !== 32'h80) begin n_err++; $display("FAIL eom_addr: got %h want 80", imem_addr_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL eom_valid: got %b want 0", instr_valid_o); end
        repeat (2) @(negedge clk_i);
        n_cmp++; if (oob_o !== 1'b1 || imem_addr_o !== 32'h80) begin n_err++; $display("FAIL eom_hold: got oob=%b addr=%h want oob=1 addr=80", oob_o, imem_addr_o); end
        redirect_i = 1'b1;
        redirect_pc_i = 32'd0;
        @(negedge clk_i);
        redirect_i = 1'b0;
        n_cmp++; if (oob_o !== 1'b0) begin n_err++; $display("FAIL eom_oob_clear: got %b want 0", oob_o); end
        n_cmp++; if (imem_addr_o !== 32'd0) begin n_err++; $display("FAIL eom_restart_addr: got %h want 0", imem_addr_o); end
        @(negedge clk_i);
        n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'd0) begin n_err++; $display("FAIL eom_resume: got valid=%b pc=%h want valid=1 pc=0", instr_valid_o, instr_pc_o); end
    endtask

    task automatic test_halt();
        logic [31:0] hold;
        @(negedge clk_i);
        hold = imem_addr_o;
        halt_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            n_cmp++; if (imem_addr_o !== hold) begin n_err++; $display("FAIL halt_addr[%0d]: got %h want %h", k, imem_addr_o, hold); end
        end
        n_cmp++; if (count_o !== '0) begin n_err++; $display("FAIL halt_drain: got %0d want 0", count_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL halt_valid: got %b want 0", instr_valid_o); end
        halt_i = 1'b0;
        @(negedge clk_i);
        n_cmp++; if (instr_pc_o !== hold) begin n_err++; $display("FAIL halt_resume_pc: got %h want %h", instr_pc_o, hold); end
        n_cmp++; if (instr_o !== 32'h1000_0000 + (hold >> 2)) begin n_err++; $display("FAIL halt_resume_instr: got %h want %h", instr_o, 32'h1000_0000 + (hold >> 2)); end
        @(negedge clk_i);
        n_cmp++; if (instr_pc_o !== hold + 32'd4) begin n_err++; $display("FAIL halt_next_pc: got %h want %h", instr_pc_o, hold + 32'd4); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        n_cmp++; if (count_o !== '0) begin n_err++; $display("FAIL mrst_count: got %0d want 0", count_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL mrst_valid: got %b want 0", instr_valid_o); end
        n_cmp++; if (instr_o !== 32'd0 || instr_pc_o !== 32'd0) begin n_err++; $display("FAIL mrst_head: got %h/%h want 0/0", instr_o, instr_pc_o); end
        n_cmp++; if (imem_addr_o !== RESET_PC) begin n_err++; $display("FAIL mrst_addr: got %h want %h", imem_addr_o, RESET_PC); end
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== RESET_PC) begin n_err++; $display("FAIL mrst_restart: got valid=%b pc=%h want 1/%h", instr_valid_o, instr_pc_o, RESET_PC); end
        @(negedge clk_i);
        n_cmp++; if (instr_pc_o !== RESET_PC + 32'd4) begin n_err++; $display("FAIL mrst_next: got %h want %h", instr_pc_o, RESET_PC + 32'd4); end
    endtask

    // Random ready/halt/redirect traffic against a queue-based model of the fetch stream.
    task automatic test_random();
        ent_t        m_q[$];
        logic [31:0] m_pc;
        bit          m_oob;
        bit          pop;
        bit          push;
        ent_t        head;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        m_pc = 32'd0;
        m_oob = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            instr_ready_i = ($urandom_range(0, 9) < 7);
            halt_i        = ($urandom_range(0, 9) == 0);
            redirect_i    = (cyc == 0) || ($urandom_range(0, 19) == 0);
            if (cyc == 0)
                redirect_pc_i = 32'd0;
            else if ($urandom_range(0, 1) == 0)
                redirect_pc_i = 32'(MEM_WORDS * 4 - 16) + 32'($urandom_range(0, 31));
            else
                redirect_pc_i = 32'($urandom_range(0, MEM_WORDS * 4 + 12));

            pop = (m_q.size() != 0) && instr_ready_i;
            if (redirect_i) begin
                m_q.delete();
                m_pc  = {redirect_pc_i[31:2], 2'b00};
                m_oob = 1'b0;
            end else begin
                push = !m_oob && (m_pc < 32'(MEM_WORDS * 4)) && !halt_i && ((m_q.size() < DEPTH) || pop);
                if (!m_oob && m_pc >= 32'(MEM_WORDS * 4)) m_oob = 1'b1;
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    m_q.push_back('{pc: m_pc, instr: mem[m_pc[AW+1:2]]});
                    m_pc = m_pc + 32'd4;
                end
            end

            @(negedge clk_i);
            head = (m_q.size() != 0) ? m_q[0] : '0;
            n_cmp++; if (count_o !== CW'(m_q.size())) begin n_err++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, count_o, m_q.size()); end
            n_cmp++; if (instr_valid_o !== (m_q.size() != 0)) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, instr_valid_o, m_q.size() != 0); end
            n_cmp++; if (instr_pc_o !== head.pc) begin n_err++; $display("FAIL rnd_pc@%0d: got %h want %h", cyc, instr_pc_o, head.pc); end
            n_cmp++; if (instr_o !== head.instr) begin n_err++; $display("FAIL rnd_instr@%0d: got %h want %h", cyc, instr_o, head.instr); end
            n_cmp++; if (imem_addr_o !== m_pc) begin n_err++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, imem_addr_o, m_pc); end
            n_cmp++; if (oob_o !== m_oob) begin n_err++; $display("FAIL rnd_oob@%0d: got %b want %b", cyc, oob_o, m_oob); end
        end
        redirect_i = 1'b0;
        halt_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h1000_0000 + 32'(i);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_end_of_memory();
        test_halt();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
